// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches a byte-coded program from a synchronous ROM,
// decodes it and issues exactly one alu_op command per instruction.
// Optional single-step mode is enabled with the macro ALU_SEQ_SINGLE_STEP_EN
// (adds Step input and Paused output, and an S_PAUSE state after each S_EXEC).

package global_pkg;
  typedef enum logic [4:0] {
    nop, op_lda, op_ldb, op_ldacc, op_ldid, op_mvacc2id, op_mvacc2a,
    op_mvacc2b, op_add, op_sub, op_shiftl, op_shiftr, op_and, op_or,
    op_xor, op_cmpe, op_cmpl, op_cmpg, op_ascii2bin, op_bin2ascii, op_oeacc
  } alu_op;
endpackage

module alu_sequencer
  import global_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  output logic [PC_W-1:0] RomAddr,
  output logic            RomRdEn,
  input  logic [7:0]      RomData,
  output alu_op           ALU_op,
  output logic [7:0]      AluData,
  input  logic [7:0]      AluOutData,
  input  logic            FlagZ,
  input  logic            FlagC,
  input  logic            FlagN,
  input  logic            FlagE,
  output logic [7:0]      OutPort,
  output logic            OutValid,
  output logic            Halted,
  output logic            IllegalOp
`ifdef ALU_SEQ_SINGLE_STEP_EN
  ,
  input  logic            Step,
  output logic            Paused
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_OPFETCH, S_OPLATCH, S_EXEC, S_HALT, S_PAUSE
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      opr_q, opr_d;
  logic [7:0]      outPort_q, outPort_d;
  logic            outValid_q, outValid_d;
  logic            illegal_q, illegal_d;

  alu_op           execOp;
  logic [7:0]      execData;
  logic            jumpTaken;
  logic            illegalSeen;

  // Bit 5 of byte0 carries no meaning in any instruction class.
  logic unusedIrBit;
  assign unusedIrBit = ir_q[5];

  assign RomAddr   = pc_q;
  assign OutPort   = outPort_q;
  assign OutValid  = outValid_q;
  assign IllegalOp = illegal_q;

  // State register with synchronous reset; Rst wins over every state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      opr_q      <= '0;
      outPort_q  <= '0;
      outValid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      opr_q      <= opr_d;
      outPort_q  <= outPort_d;
      outValid_q <= outValid_d;
      illegal_q  <= illegal_d;
    end
  end

  // Decode the latched instruction into the command, operand and jump decision.
  always_comb begin
    execOp      = nop;
    execData    = '0;
    jumpTaken   = 1'b0;
    illegalSeen = 1'b0;
    case (ir_q[7:6])
      2'b00: begin
        if (ir_q[4:0] > op_oeacc) illegalSeen = 1'b1;
        else                      execOp = alu_op'(ir_q[4:0]);
      end
      2'b01: begin
        execData = opr_q;
        case (ir_q[1:0])
          2'b00:   execOp = op_lda;
          2'b01:   execOp = op_ldb;
          2'b10:   execOp = op_ldacc;
          default: execOp = op_ldid;
        endcase
      end
      2'b10: begin
        case (ir_q[2:0])
          3'b000:  jumpTaken = 1'b1;
          3'b001:  jumpTaken = FlagZ;
          3'b010:  jumpTaken = ~FlagZ;
          3'b011:  jumpTaken = FlagC;
          3'b100:  jumpTaken = FlagN;
          3'b101:  jumpTaken = FlagE;
          default: illegalSeen = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // Next-state logic: sequencing, PC update, operand capture, output capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    opr_d      = opr_q;
    outPort_d  = outPort_q;
    outValid_d = 1'b0;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE:    if (Start) state_d = S_FETCH;
      S_FETCH:   state_d = S_LATCH;
      S_LATCH: begin
        ir_d = RomData;
        pc_d = pc_q + PC_W'(1);
        if (RomData[7:6] == 2'b01 || RomData[7:6] == 2'b10) state_d = S_OPFETCH;
        else                                                 state_d = S_EXEC;
      end
      S_OPFETCH: state_d = S_OPLATCH;
      S_OPLATCH: begin
        opr_d   = RomData;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (illegalSeen) illegal_d = 1'b1;
        if (jumpTaken)   pc_d = opr_q[PC_W-1:0];
        if (execOp == op_oeacc) begin
          outPort_d  = AluOutData;
          outValid_d = 1'b1;
        end
        if (ir_q[7:6] == 2'b11) state_d = S_HALT;
`ifdef ALU_SEQ_SINGLE_STEP_EN
        else                    state_d = S_PAUSE;
`else
        else                    state_d = S_FETCH;
`endif
      end
`ifdef ALU_SEQ_SINGLE_STEP_EN
      S_PAUSE:   if (Step) state_d = S_FETCH;
`endif
      default:   state_d = state_q;
    endcase
  end

  // Output logic: the ALU only ever sees a command during S_EXEC.
  always_comb begin
    ALU_op  = nop;
    AluData = '0;
    RomRdEn = 1'b0;
    Halted  = 1'b0;
`ifdef ALU_SEQ_SINGLE_STEP_EN
    Paused  = (state_q == S_PAUSE);
`endif
    case (state_q)
      S_FETCH, S_OPFETCH: RomRdEn = 1'b1;
      S_EXEC: begin
        ALU_op  = execOp;
        AluData = execData;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule
